// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the radix-2 DIT FFT sequencer.
//   - FSM state encodings (3-bit, legacy-compatible constants)
//   - clog2     : ceiling log2, usable in parameter expressions
//   - bit_rev   : reverse the low 'width' bits of a value
package fft_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_OUTPUT  = 3'd4;

  // Bounded loop so the function stays elaboration- and synthesis-friendly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Butterfly address generator plus write-back delay line.
//   clk, rstn        : clock, async active-low reset
//   issue            : a butterfly is issued this cycle (FSM in COMPUTE)
//   s, k             : stage index and butterfly index within the stage
//   rd_addr0_o/1_o   : registered upper/lower leg read addresses
//   rd_en_o          : registered read enable
//   twiddle_addr_o   : registered twiddle ROM address, aligned with rd_addr*
//   wr_addr0_o/1_o   : read addresses delayed BF_LAT cycles
//   wr_en_o          : read enable delayed BF_LAT cycles (butterfly result valid)
module fft_bf_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int N      = 1024,
  parameter int BF_LAT = 3,
  localparam int L     = clog2(N),
  localparam int AW    = L,
  localparam int SW    = clog2(L) + 1
)(
  input  logic          clk,
  input  logic          rstn,
  input  logic          issue,
  input  logic [SW-1:0] s,
  input  logic [AW-2:0] k,
  output logic [AW-1:0] rd_addr0_o,
  output logic [AW-1:0] rd_addr1_o,
  output logic          rd_en_o,
  output logic [AW-2:0] twiddle_addr_o,
  output logic [AW-1:0] wr_addr0_o,
  output logic [AW-1:0] wr_addr1_o,
  output logic          wr_en_o
);

  logic [AW-1:0] k_ext;
  logic [AW-1:0] half;
  logic [AW-1:0] lo;
  logic [AW-1:0] a0;
  logic [AW-1:0] a1;
  logic [AW-2:0] tw;

  // Butterfly k of stage s: group index k>>s selects a 2*half block, the low
  // s bits of k select the pair inside it; the twiddle stride shrinks as
  // the span grows.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    k_ext = {1'b0, k};
    half  = AW'(1) << s;
    lo    = k_ext & (half - AW'(1));
    a0    = ((k_ext >> s) << (s + SW'(1))) | lo;
    a1    = a0 + half;
    tw    = (AW-1)'(lo << (SW'(L - 1) - s));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr0_o     <= '0;
      rd_addr1_o     <= '0;
      twiddle_addr_o <= '0;
      rd_en_o        <= 1'b0;
    end else if (issue) begin
      rd_addr0_o     <= a0;
      rd_addr1_o     <= a1;
      twiddle_addr_o <= tw;
      rd_en_o        <= 1'b1;
    end else begin
      rd_addr0_o     <= '0;
      rd_addr1_o     <= '0;
      twiddle_addr_o <= '0;
      rd_en_o        <= 1'b0;
    end
  end

  // Write-back delay line: one slot per cycle of BRAM read + butterfly
  // pipeline, so write-back order and spacing match the read stream.
  logic [AW-1:0] dl_a0 [BF_LAT];
  logic [AW-1:0] dl_a1 [BF_LAT];
  logic          dl_en [BF_LAT];

  // NOTE: this array is reset on purpose: a stale enable left in the line
  // after an abort would fire a spurious write-back. Pure data storage
  // (e.g. sample RAM) would normally not be reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a0[i] <= '0;
        dl_a1[i] <= '0;
        dl_en[i] <= 1'b0;
      end
    end else begin
      dl_a0[0] <= rd_addr0_o;
      dl_a1[0] <= rd_addr1_o;
      dl_en[0] <= rd_en_o;
      for (int i = 1; i < BF_LAT; i++) begin
        dl_a0[i] <= dl_a0[i-1];
        dl_a1[i] <= dl_a1[i-1];
        dl_en[i] <= dl_en[i-1];
      end
    end
  end

  assign wr_addr0_o = dl_a0[BF_LAT-1];
  assign wr_addr1_o = dl_a1[BF_LAT-1];
  assign wr_en_o    = dl_en[BF_LAT-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for the in-place radix-2 DIT FFT core.
// Phases: LOAD (bit-reversed sample writes), COMPUTE/DRAIN per stage,
// OUTPUT (natural-order streaming). All outputs are registered and lag the
// FSM state by one cycle; rd/twiddle come from fft_bf_addr_gen.
//   clk, rstn       : clock, async active-low reset
//   start_i         : begin a transform (IDLE only)
//   load_we_o       : sample write enable, load_addr_o bit-reversed address
//   rd_*_o          : butterfly read legs/enable, twiddle_addr_o
//   wr_*_o          : write-back legs/enable (BF_LAT after the read)
//   out_addr_o      : result read address while fft_ready_o is high
//   stage_o         : current stage (0 outside COMPUTE/DRAIN)
//   state_o         : FSM state, debug
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N      = 1024,
  parameter int BF_LAT = 3,
  localparam int L     = clog2(N),
  localparam int AW    = L,
  localparam int SW    = clog2(L) + 1
)(
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_i,
  output logic          load_we_o,
  output logic [AW-1:0] load_addr_o,
  output logic [AW-1:0] rd_addr0_o,
  output logic [AW-1:0] rd_addr1_o,
  output logic          rd_en_o,
  output logic [AW-2:0] twiddle_addr_o,
  output logic [AW-1:0] wr_addr0_o,
  output logic [AW-1:0] wr_addr1_o,
  output logic          wr_en_o,
  output logic [AW-1:0] out_addr_o,
  output logic          fft_ready_o,
  output logic [SW-1:0] stage_o,
  output logic [2:0]    state_o
);

  localparam logic [AW:0]   CNT_N_LAST  = (AW+1)'(N - 1);
  localparam logic [AW:0]   CNT_BF_LAST = (AW+1)'(BF_LAT - 1);
  localparam logic [AW-2:0] K_LAST      = (AW-1)'(N/2 - 1);
  localparam logic [SW-1:0] S_LAST      = SW'(L - 1);

  logic [2:0]    state;
  logic [AW:0]   cnt;   // LOAD/OUTPUT sample index, DRAIN cycle count
  logic [SW-1:0] s;
  logic [AW-2:0] k;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      s     <= '0;
      k     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (cnt == CNT_N_LAST) begin
            state <= ST_COMPUTE;
            cnt   <= '0;
            s     <= '0;
            k     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (k == K_LAST) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Wait out the write-back pipeline before the next stage reads.
          if (cnt == CNT_BF_LAST) begin
            cnt <= '0;
            if (s == S_LAST) begin
              state <= ST_OUTPUT;
            end else begin
              state <= ST_COMPUTE;
              s     <= s + 1'b1;
              k     <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (cnt == CNT_N_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_we_o   <= 1'b0;
      load_addr_o <= '0;
      out_addr_o  <= '0;
      fft_ready_o <= 1'b0;
      stage_o     <= '0;
      state_o     <= ST_IDLE;
    end else begin
      load_we_o   <= (state == ST_LOAD);
      load_addr_o <= (state == ST_LOAD) ? AW'(bit_rev(32'(cnt[AW-1:0]), AW)) : '0;
      out_addr_o  <= (state == ST_OUTPUT) ? cnt[AW-1:0] : '0;
      fft_ready_o <= (state == ST_OUTPUT);
      stage_o     <= (state == ST_COMPUTE || state == ST_DRAIN) ? s : '0;
      state_o     <= state;
    end
  end

  fft_bf_addr_gen #(
    .N      (N),
    .BF_LAT (BF_LAT)
  ) u_addr_gen (
    .clk            (clk),
    .rstn           (rstn),
    .issue          (state == ST_COMPUTE),
    .s              (s),
    .k              (k),
    .rd_addr0_o     (rd_addr0_o),
    .rd_addr1_o     (rd_addr1_o),
    .rd_en_o        (rd_en_o),
    .twiddle_addr_o (twiddle_addr_o),
    .wr_addr0_o     (wr_addr0_o),
    .wr_addr1_o     (wr_addr1_o),
    .wr_en_o        (wr_en_o)
  );

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl at N=16, BF_LAT=3.
// A golden per-cycle trace is built from the transform's definition
// (bit-reversed load order, group/pair enumeration per stage, drain gaps,
// natural-order output) and compared against the DUT outputs every cycle.
module tb_fft_stage_ctrl;

  localparam int N   = 16;
  localparam int BF  = 3;
  localparam int L   = 4;
  localparam int AW  = 4;
  localparam int SW  = 3;
  localparam int FIRST_RDY = N + L*(N/2 + BF) + 1;   // 61
  localparam int LAST_RDY  = FIRST_RDY + N - 1;      // 76
  localparam int TOT       = LAST_RDY + 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_i = 1'b0;
  logic          load_we_o;
  logic [AW-1:0] load_addr_o;
  logic [AW-1:0] rd_addr0_o;
  logic [AW-1:0] rd_addr1_o;
  logic          rd_en_o;
  logic [AW-2:0] twiddle_addr_o;
  logic [AW-1:0] wr_addr0_o;
  logic [AW-1:0] wr_addr1_o;
  logic          wr_en_o;
  logic [AW-1:0] out_addr_o;
  logic          fft_ready_o;
  logic [SW-1:0] stage_o;
  logic [2:0]    state_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic          rd_en;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-2:0] tw;
    logic          wr_en;
    logic [AW-1:0] w0;
    logic [AW-1:0] w1;
    logic          ready;
    logic [AW-1:0] out_addr;
    logic [SW-1:0] stage;
    logic [2:0]    state;
  } obs_t;

  obs_t exp_tr [TOT];

  fft_stage_ctrl #(.N(N), .BF_LAT(BF)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (start_i),
    .load_we_o      (load_we_o),
    .load_addr_o    (load_addr_o),
    .rd_addr0_o     (rd_addr0_o),
    .rd_addr1_o     (rd_addr1_o),
    .rd_en_o        (rd_en_o),
    .twiddle_addr_o (twiddle_addr_o),
    .wr_addr0_o     (wr_addr0_o),
    .wr_addr1_o     (wr_addr1_o),
    .wr_en_o        (wr_en_o),
    .out_addr_o     (out_addr_o),
    .fft_ready_o    (fft_ready_o),
    .stage_o        (stage_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.ld_we    = load_we_o;
    o.ld_addr  = load_addr_o;
    o.rd_en    = rd_en_o;
    o.a0       = rd_addr0_o;
    o.a1       = rd_addr1_o;
    o.tw       = twiddle_addr_o;
    o.wr_en    = wr_en_o;
    o.w0       = wr_addr0_o;
    o.w1       = wr_addr1_o;
    o.ready    = fft_ready_o;
    o.out_addr = out_addr_o;
    o.stage    = stage_o;
    o.state    = state_o;
    return o;
  endfunction

  // Index c = outputs observed just after the c-th rising edge counted from
  // the edge that samples start_i (c=0).
  task automatic build_model();
    int c;
    for (int i = 0; i < TOT; i++) exp_tr[i] = '0;
    c = 1;
    for (int i = 0; i < N; i++) begin
      int r, v;
      r = 0;
      v = i;
      for (int b = 0; b < L; b++) begin
        r = r * 2 + (v % 2);
        v = v / 2;
      end
      exp_tr[c].ld_we   = 1'b1;
      exp_tr[c].ld_addr = AW'(r);
      exp_tr[c].state   = 3'd1;
      c++;
    end
    for (int st = 0; st < L; st++) begin
      int half;
      half = 1 << st;
      for (int g = 0; g < N / (2 * half); g++) begin
        for (int j = 0; j < half; j++) begin
          exp_tr[c].rd_en = 1'b1;
          exp_tr[c].a0    = AW'(g * 2 * half + j);
          exp_tr[c].a1    = AW'(g * 2 * half + j + half);
          exp_tr[c].tw    = (AW-1)'(j * (N / (2 * half)));
          exp_tr[c].stage = SW'(st);
          exp_tr[c].state = 3'd2;
          c++;
        end
      end
      for (int d = 0; d < BF; d++) begin
        exp_tr[c].stage = SW'(st);
        exp_tr[c].state = 3'd3;
        c++;
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_tr[c].ready    = 1'b1;
      exp_tr[c].out_addr = AW'(i);
      exp_tr[c].state    = 3'd4;
      c++;
    end
    for (int i = BF; i < TOT; i++) begin
      exp_tr[i].wr_en = exp_tr[i-BF].rd_en;
      exp_tr[i].w0    = exp_tr[i-BF].a0;
      exp_tr[i].w1    = exp_tr[i-BF].a1;
    end
  endtask

  // Caller sets start_i=1 so that the next rising edge samples it.
  task automatic run_trace(input bit disturb, input bit chain, input string tag);
    obs_t o;
    int first_rdy;
    int rdy_cnt;
    first_rdy = -1;
    rdy_cnt   = 0;
    for (int c = 0; c < TOT; c++) begin
      @(posedge clk);
      #1;
      o = sample();
      total++;
      if (o !== exp_tr[c]) begin
        bad++;
        $display("FAIL %s trace cycle %0d: got %h expected %h", tag, c, o, exp_tr[c]);
      end
      if (o.ready === 1'b1) begin
        if (first_rdy < 0) first_rdy = c;
        rdy_cnt++;
      end
      start_i = 1'b0;
      // Stray starts while busy; never in the cycle the FSM sits in IDLE.
      if (disturb && (exp_tr[c].state inside {3'd1, 3'd2, 3'd3} ||
          (exp_tr[c].state == 3'd4 && exp_tr[c].out_addr != AW'(N-1))) &&
          $urandom_range(0, 2) == 0)
        start_i = 1'b1;
      if (chain && c == LAST_RDY) begin
        start_i = 1'b1;
        break;
      end
    end
    total++;
    if (first_rdy !== FIRST_RDY) begin
      bad++;
      $display("FAIL %s latency: got %0d expected %0d", tag, first_rdy, FIRST_RDY);
    end
    total++;
    if (rdy_cnt !== N) begin
      bad++;
      $display("FAIL %s ready_cycles: got %0d expected %0d", tag, rdy_cnt, N);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      o = sample();
      total++;
      if (o !== obs_t'('0)) begin
        bad++;
        $display("FAIL %s idle: got %h expected 0", tag, o);
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rstn    = 1'b0;
    start_i = 1'b1;          // must not matter while in reset
    #2;
    o = sample();
    total++;
    if (o !== obs_t'('0)) begin
      bad++;
      $display("FAIL reset_initial: got %h expected 0", o);
    end
    repeat (3) @(posedge clk);
    #1;
    o = sample();
    total++;
    if (o !== obs_t'('0)) begin
      bad++;
      $display("FAIL reset_held: got %h expected 0", o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle_cycles($urandom_range(2, 5), "post_reset");
  endtask

  task automatic test_golden();
    start_i = 1'b1;
    run_trace(1'b0, 1'b0, "golden");
  endtask

  task automatic test_start_ignored();
    idle_cycles($urandom_range(1, 4), "pre_disturb");
    start_i = 1'b1;
    run_trace(1'b1, 1'b0, "start_ignored");
  endtask

  task automatic test_mid_reset();
    obs_t o;
    int stop_c;
    stop_c = 1 + N + 2*(N/2 + BF) + $urandom_range(0, N/2 - 1);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int c = 1; c <= stop_c; c++) begin
      @(posedge clk);
      #1;
    end
    o = sample();
    total++;
    if (o.stage !== SW'(2) || o.rd_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_pre: got stage %0d rd_en %0d expected stage 2 rd_en 1",
               o.stage, o.rd_en);
    end
    #($urandom_range(1, 2));
    rstn = 1'b0;
    #1;
    o = sample();
    total++;
    if (o !== obs_t'('0)) begin
      bad++;
      $display("FAIL mid_reset_async: got %h expected 0", o);
    end
    @(posedge clk);
    #1;
    o = sample();
    total++;
    if (o !== obs_t'('0)) begin
      bad++;
      $display("FAIL mid_reset_held: got %h expected 0", o);
    end
    @(negedge clk);
    rstn = 1'b1;
    idle_cycles(2, "after_abort");
    start_i = 1'b1;
    run_trace(1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    idle_cycles($urandom_range(1, 3), "pre_b2b");
    start_i = 1'b1;
    run_trace(1'b0, 1'b1, "b2b_first");
    run_trace(1'b0, 1'b0, "b2b_second");
  endtask

  initial begin
    build_model();
    test_reset();
    test_golden();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    idle_cycles(3, "final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
- Sequencer for the in-place radix-2 DIT FFT core. Drives the sample/result BRAM ports, the twiddle ROM and the butterfly write-back.
- Runs a full transform in three phases:
  - LOAD: N samples written in bit-reversed order.
  - COMPUTE: log2(N) stages of N/2 butterflies each.
  - OUTPUT: N results streamed in natural order with fft_ready_o high.
- Sits between the top-level fft_1024_point wrapper and its BRAM, butterfly and twiddle instances. Replaces the ad-hoc state/address logic currently inside the wrapper.

Parameters:
- N, 1024, transform length; power of two, 8..4096. L = log2(N), AW = log2(N).
- BF_LAT, 3, cycles from read-address issue to butterfly result valid (BRAM read plus butterfly pipeline); 1..8.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- start_i  in  1  begin transform; sampled in IDLE only
- load_we_o  out  1  sample write enable during LOAD
- load_addr_o  out  AW  bit-reversed write address for the incoming sample
- rd_addr0_o  out  AW  butterfly upper-leg read address
- rd_addr1_o  out  AW  butterfly lower-leg read address
- rd_en_o  out  1  read enable, both legs
- twiddle_addr_o  out  AW-1  twiddle ROM address, aligned with rd_addr*
- wr_addr0_o  out  AW  write-back address, upper leg
- wr_addr1_o  out  AW  write-back address, lower leg
- wr_en_o  out  1  write-back enable; coincides with butterfly result valid
- out_addr_o  out  AW  natural-order result read address
- fft_ready_o  out  1  high for exactly N cycles while results stream
- stage_o  out  log2(L)+1  current stage index
- state_o  out  3  FSM state, for debug

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and the delay line cleared. Asserting rstn low mid-transform aborts immediately; there is no partial completion.
- States: IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3, OUTPUT=4.
- IDLE: on start_i=1, go to LOAD next cycle with cnt=0. start_i is ignored in every other state.
- LOAD:
  - load_we_o=1 for N consecutive cycles.
  - load_addr_o = bit-reverse of cnt (L bits).
  - On cnt==N-1, go to COMPUTE with s=0, k=0.
- COMPUTE (stage s, butterfly k in 0..N/2-1):
  - half = 1<<s
  - rd_addr0 = ((k>>s)<<(s+1)) | (k & (half-1))
  - rd_addr1 = rd_addr0 + half
  - twiddle_addr = (k & (half-1)) << (L-1-s)
  - rd_en_o=1 every COMPUTE cycle; one butterfly issued per cycle.
  - On k==N/2-1, go to DRAIN.
- Write-back path:
  - rd_addr0/rd_addr1 and rd_en pass through a BF_LAT-deep shift register.
  - Its outputs drive wr_addr0_o, wr_addr1_o and wr_en_o.
  - wr_en_o fires exactly BF_LAT cycles after each rd_en_o; no bubbles, no reordering.
- DRAIN:
  - Hold for BF_LAT cycles with rd_en_o=0 so stage s writes finish before stage s+1 reads (RAW hazard).
  - Then, if s<L-1: s++, k=0, go to COMPUTE. Otherwise go to OUTPUT with cnt=0.
- OUTPUT:
  - fft_ready_o=1; out_addr_o = cnt, incrementing 0..N-1.
  - After cnt==N-1: fft_ready_o drops, go to IDLE.
  - A start_i already high in that IDLE cycle begins a new transform on the next edge.
- Latency:
  - start_i sampled to first fft_ready_o = N + L*(N/2+BF_LAT) + 1 cycles.
  - N=16, BF_LAT=3 gives 61.
  - N=1024, BF_LAT=3 gives 6175.
- Widths and wrap:
  - All address arithmetic is unsigned AW bits; rd_addr1 never exceeds N-1 by construction.
  - cnt is AW+1 bits; terminal-count compares use ==, never overflow.
- stage_o holds s through DRAIN and reads 0 outside COMPUTE/DRAIN.

Decomposition:
- Package fft_ctrl_pkg:
  - state encodings (IDLE..OUTPUT)
  - function bit_rev(value, width)
  - function clog2 helper
- One sub-module, fft_bf_addr_gen:
  - registered generator for rd_addr0/1 and twiddle_addr from (s, k)
  - includes the BF_LAT write-back delay line
- The FSM and counters stay in fft_stage_ctrl.

Test Plan:
- N=16, BF_LAT=3: reset, pulse start_i → load_addr_o sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with load_we_o high for 16 cycles.
- Stage 0 → (rd_addr0, rd_addr1, twiddle) = (0,1,0), (2,3,0) … (14,15,0).
- Stage 2 → (0,4,0), (1,5,2), (2,6,4), (3,7,6), (8,12,0) …
- Stage 3 → (0,8,0) … (7,15,7).
- Every cycle: wr_addr0_o/wr_addr1_o/wr_en_o equal rd_addr0_o/rd_addr1_o/rd_en_o delayed exactly 3 cycles.
- Every DRAIN: rd_en_o=0 for 3 cycles; no read of stage s+1 before the final stage-s write.
- First fft_ready_o occurs 61 cycles after start_i sampled; high exactly 16 cycles; out_addr_o=0..15.
- Pulse start_i during COMPUTE → ignored; the stage/address trace is identical to an undisturbed run.
- Assert rstn=0 mid-stage-2 → all outputs 0 asynchronously; a fresh start_i after release reproduces the golden trace from LOAD.
- Back-to-back run: start_i high on the cycle after the last fft_ready_o → second transform starts; trace is identical to the first.
